// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] pc;
    logic [DEFAULT_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = $bits(fetch_entry_t)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  // When full, a simultaneous push overwrites the slot being popped, which is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: sequential PC with redirect, buffered into a 2-entry FIFO toward decode.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH   = 32,
  parameter int unsigned          ENTRY_COUNT = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [BIT_WIDTH-1:0] read_address,
  input  logic [BIT_WIDTH-1:0] read_data,
  input  logic                 redirect_valid,
  input  logic [BIT_WIDTH-1:0] redirect_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_instr,
  output logic [BIT_WIDTH-1:0] out_pc,
  output logic                 halted
);

  typedef struct packed {
    logic [BIT_WIDTH-1:0] pc;
    logic [BIT_WIDTH-1:0] instr;
  } entry_t;

  localparam logic [BIT_WIDTH-1:0] FETCH_LIMIT = BIT_WIDTH'(ENTRY_COUNT * INSTR_BYTES);
  localparam fetch_state_t         RESET_STATE = (RESET_PC >= FETCH_LIMIT) ? HALT : RUN;

  fetch_state_t         state;
  fetch_state_t         state_next;
  logic [BIT_WIDTH-1:0] pc;
  logic [BIT_WIDTH-1:0] pc_next;
  logic [BIT_WIDTH-1:0] pc_plus;
  logic [BIT_WIDTH-1:0] target;
  logic [1:0]           count;
  logic                 raw_pop;
  logic                 can_push;
  logic                 push;
  logic                 pop;
  logic                 flush;
  entry_t               push_entry;
  entry_t               head;

  assign pc_plus    = pc + BIT_WIDTH'(INSTR_BYTES);
  assign target     = {redirect_target[BIT_WIDTH-1:2], 2'b00};
  assign raw_pop    = out_valid && out_ready;
  assign can_push   = (count != 2'd2) || raw_pop;
  assign push_entry = '{pc: pc, instr: read_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_valid) begin
      state_next = (target >= FETCH_LIMIT) ? HALT : RUN;
      pc_next    = target;
    end else begin
      case (state)
        RUN: begin
          if (pc >= FETCH_LIMIT) begin
            state_next = HALT;
          end else if (!can_push) begin
            state_next = STALL;
          end else begin
            pc_next = pc_plus;
            if (pc_plus == FETCH_LIMIT) state_next = HALT;
          end
        end
        STALL:   if (raw_pop) state_next = RUN;
        HALT:    state_next = HALT;
        default: state_next = RUN;
      endcase
    end
  end

  // Redirect overrides everything: the FIFO flushes and neither push nor pop happens.
  always_comb begin
    flush  = redirect_valid;
    push   = !redirect_valid && (state == RUN) && can_push && (pc < FETCH_LIMIT);
    pop    = !redirect_valid && raw_pop;
    halted = (state == HALT);
  end

  fetch_fifo #(
    .WIDTH($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head      (head),
    .count     (count)
  );

  assign read_address = pc;
  assign out_valid    = (count != 2'd0);
  assign out_instr    = head.instr;
  assign out_pc       = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected pairs are queued per scenario and popped on each accepted transfer.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  int unsigned  xfers    = 0;
  fetch_entry_t sb[$];
  fetch_entry_t exp_e;

  always #5 clk = ~clk;

  // Instruction memory: word i holds 0x1000_0000 + i.
  assign read_data = 32'h1000_0000 + (read_address >> 2);

  instruction_fetch #(
    .BIT_WIDTH   (32),
    .ENTRY_COUNT (32),
    .RESET_PC    (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .read_address    (read_address),
    .read_data       (read_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .halted          (halted)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_range(input int unsigned first, input int unsigned last);
    for (int unsigned a = first; a <= last; a += 4)
      sb.push_back('{pc: a, instr: 32'h1000_0000 + (a >> 2)});
  endtask

  // A transfer happens at the next rising edge when valid && ready (redirect suppresses the pop).
  always @(negedge clk) begin
    if (!rst && !redirect_valid && out_valid && out_ready) begin
      xfers++;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        exp_e = sb.pop_front();
        check_eq("out_pc", 64'(out_pc), 64'(exp_e.pc));
        check_eq("out_instr", 64'(out_instr), 64'(exp_e.instr));
      end
    end
  end

  task automatic apply_reset(input bit check_outputs);
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    #2;
    if (check_outputs) begin
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_halted", 64'(halted), 64'd0);
      check_eq("rst_read_address", 64'(read_address), 64'h0);
      check_eq("rst_out_instr", 64'(out_instr), 64'h0);
      check_eq("rst_out_pc", 64'(out_pc), 64'h0);
    end
    repeat (2) @(negedge clk);
    sb.delete();
    xfers = 0;
    rst   = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] tgt, input logic ready_val);
    @(posedge clk);
    #1;
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    out_ready       = ready_val;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    check_eq("post_redirect_gap", 64'(out_valid), 64'd0);
  endtask

  initial begin
    // Full sequential run with decode always ready, through to HALT.
    apply_reset(1'b1);
    out_ready = 1'b1;
    expect_range(32'h00, 32'h7C);
    @(posedge clk);
    #1;
    check_eq("first_latency", 64'(out_valid), 64'd1);
    repeat (32) @(posedge clk);
    #1;
    check_eq("run_xfers", 64'(xfers), 64'd32);
    check_eq("run_sb_drained", 64'(sb.size()), 64'd0);
    check_eq("end_halted", 64'(halted), 64'd1);
    check_eq("end_read_address", 64'(read_address), 64'h80);
    check_eq("end_out_valid", 64'(out_valid), 64'd0);

    // Redirect out of HALT.
    sb.delete();
    expect_range(32'h10, 32'h7C);
    do_redirect(32'h10, 1'b1);
    check_eq("resume_halted", 64'(halted), 64'd0);
    check_eq("resume_read_address", 64'(read_address), 64'h10);
    repeat (32) @(posedge clk);
    #1;
    check_eq("resume_sb_drained", 64'(sb.size()), 64'd0);
    check_eq("resume_halted_again", 64'(halted), 64'd1);

    // Backpressure from reset: two buffered, PC stalled at 0x08.
    apply_reset(1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("stall_count", 64'(dut.count), 64'd2);
    check_eq("stall_state", 64'(dut.state), 64'(STALL));
    check_eq("stall_read_address", 64'(read_address), 64'h08);
    check_eq("stall_head_pc", 64'(out_pc), 64'h00);
    expect_range(32'h00, 32'h7C);
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("stall_sb_drained", 64'(sb.size()), 64'd0);
    check_eq("stall_xfers", 64'(xfers), 64'd32);

    // Redirect while full: buffered 0x00/0x04 must be discarded.
    apply_reset(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("full_count", 64'(dut.count), 64'd2);
    expect_range(32'h40, 32'h7C);
    do_redirect(32'h40, 1'b1);
    @(posedge clk);
    #1;
    check_eq("redirect_first_valid", 64'(out_valid), 64'd1);
    check_eq("redirect_first_pc", 64'(out_pc), 64'h40);
    repeat (20) @(posedge clk);
    #1;
    check_eq("redirect_sb_drained", 64'(sb.size()), 64'd0);

    // Misaligned target is word-aligned.
    sb.delete();
    expect_range(32'h20, 32'h7C);
    do_redirect(32'h23, 1'b1);
    check_eq("align_read_address", 64'(read_address), 64'h20);
    repeat (28) @(posedge clk);
    #1;
    check_eq("align_sb_drained", 64'(sb.size()), 64'd0);

    // Redirect past the end of memory goes straight to HALT without fetching.
    sb.delete();
    do_redirect(32'h84, 1'b1);
    check_eq("oob_halted", 64'(halted), 64'd1);
    check_eq("oob_read_address", 64'(read_address), 64'h84);
    repeat (3) @(posedge clk);
    #1;
    check_eq("oob_no_fetch", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-cycle with a full FIFO.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_async_count", 64'(dut.count), 64'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_out_valid", 64'(out_valid), 64'd0);
    check_eq("async_read_address", 64'(read_address), 64'h0);
    repeat (2) @(negedge clk);
    expect_range(32'h00, 32'h7C);
    xfers     = 0;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("async_sb_drained", 64'(sb.size()), 64'd0);
    check_eq("async_xfers", 64'(xfers), 64'd32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
